// File: rtl/moore_seq_detect.sv
// Moore-style serial pattern detector: shifts in x on enabled clocks and raises a
// registered one-cycle z when the last PAT_W bits equal a programmable pattern.
module moore_seq_detect #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             x,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    input  logic             clear,
    output logic             z,
    output logic [CNT_W-1:0] match_count,
    output logic             count_sat
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic              z_q, z_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [PAT_W-1:0]  nh;
    logic [FILL_W-1:0] nf;
    logic              hit;

    // Candidate history/fill if this edge consumes x; fill saturates at PAT_W.
    always_comb begin
        nh  = {hist_q[PAT_W-2:0], x};
        nf  = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        hit = (nh == pattern) && (nf == FILL_FULL);
    end

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        cnt_d  = cnt_q;
        z_d    = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
            cnt_d  = '0;
        end else if (en) begin
            hist_d = nh;
            z_d    = hit;
            // Non-overlap restarts the fill so the next match needs PAT_W fresh bits.
            fill_d = (hit && !overlap) ? '0 : nf;
            if (hit && !(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
            z_q    <= 1'b0;
            cnt_q  <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
            z_q    <= z_d;
            cnt_q  <= cnt_d;
        end
    end

    assign z           = z_q;
    assign match_count = cnt_q;
    assign count_sat   = &cnt_q;

endmodule

// File: tb/tb_moore_seq_detect.sv
// Bench for moore_seq_detect: two instances (CNT_W=8 and CNT_W=2) share stimulus;
// a bit-window reference model feeds an expected queue drained by a monitor.
module tb_moore_seq_detect;

    localparam int PAT_W = 4;
    localparam int EW    = 14;

    logic             clk;
    logic             reset;
    logic             en;
    logic             x;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic             clear;

    logic             z_a, sat_a, z_b, sat_b;
    logic [7:0]       cnt_a;
    logic [1:0]       cnt_b;

    moore_seq_detect #(.PAT_W(PAT_W), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .x(x), .pattern(pattern),
        .overlap(overlap), .clear(clear),
        .z(z_a), .match_count(cnt_a), .count_sat(sat_a)
    );

    moore_seq_detect #(.PAT_W(PAT_W), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .en(en), .x(x), .pattern(pattern),
        .overlap(overlap), .clear(clear),
        .z(z_b), .match_count(cnt_b), .count_sat(sat_b)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // scoreboard state
    logic [EW-1:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    // reference model: bits received since the last reset/clear/non-overlap match
    bit win[$];
    int m_cnt8 = 0;
    int m_cnt2 = 0;
    bit m_z    = 1'b0;

    function automatic logic [EW-1:0] model_vec();
        logic [7:0] c8;
        logic [1:0] c2;
        c8 = m_cnt8[7:0];
        c2 = m_cnt2[1:0];
        return {m_z, c8, (m_cnt8 == 255), m_z, c2, (m_cnt2 == 3)};
    endfunction

    function automatic logic [EW-1:0] dut_vec();
        return {z_a, cnt_a, sat_a, z_b, cnt_b, sat_b};
    endfunction

    task automatic model_reset();
        win.delete();
        m_cnt8 = 0;
        m_cnt2 = 0;
        m_z    = 1'b0;
    endtask

    task automatic model_edge(input logic e, input logic xb, input logic clr,
                              input logic [PAT_W-1:0] pat, input logic ovl);
        bit hit;
        if (clr) begin
            model_reset();
        end else if (e) begin
            win.push_back(xb);
            if (win.size() > PAT_W) void'(win.pop_front());
            hit = (win.size() == PAT_W);
            for (int i = 0; i < PAT_W; i++) begin
                if (hit && win[i] != pat[PAT_W-1-i]) hit = 1'b0;
            end
            m_z = hit;
            if (hit) begin
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!ovl) win.delete();
            end
        end else begin
            m_z = 1'b0;
        end
    endtask

    task automatic check_now(input string name);
        logic [EW-1:0] got, want;
        got  = dut_vec();
        want = model_vec();
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
        end
    endtask

    // monitor: outputs are valid every cycle, sampled on the falling edge
    always begin
        logic [EW-1:0] want;
        @(negedge clk);
        if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            total++;
            if (dut_vec() !== want) begin
                bad++;
                $display("FAIL out_check t=%0t got=%h want=%h", $time, dut_vec(), want);
            end
        end
    end

    // driver tasks
    task automatic step(input logic e, input logic xb, input logic clr);
        en    = e;
        x     = xb;
        clear = clr;
        @(posedge clk);
        model_edge(e, xb, clr, pattern, overlap);
        exp_q.push_back(model_vec());
        @(negedge clk);
    endtask

    task automatic feed(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) step(1'b1, bits[i], 1'b0);
    endtask

    // asynchronous reset pulse placed between edges
    task automatic async_reset(input string name);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_now(name);
        #1;
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        x       = 1'b0;
        clear   = 1'b0;
        pattern = 4'b1011;
        overlap = 1'b1;
        #1;
        model_reset();
        check_now("reset_state");
        @(negedge clk);
        reset = 1'b0;

        // overlapping matches on 1011011
        overlap = 1'b1;
        feed(16'b1011011, 7);

        // non-overlapping, then a fresh match
        async_reset("reset_t2");
        overlap = 1'b0;
        feed(16'b1011011, 7);
        feed(16'b1011, 4);

        // enable gaps
        async_reset("reset_t3");
        overlap = 1'b1;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // zero pattern must not hit before four bits are in
        async_reset("reset_t4");
        pattern = 4'b0000;
        feed(16'b0, 6);

        // saturation of the narrow counter, then clear
        async_reset("reset_t5");
        pattern = 4'b1111;
        feed(16'hFFFF, 8);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // reset and clear mid-pattern
        async_reset("reset_t6a");
        pattern = 4'b1011;
        feed(16'b101, 3);
        async_reset("reset_mid");
        feed(16'b1, 1);
        feed(16'b1011, 4);
        feed(16'b101, 3);
        step(1'b1, 1'b1, 1'b1);
        feed(16'b1, 1);
        feed(16'b1011, 4);

        // randomized traffic
        async_reset("reset_rand");
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) pattern = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 29) == 0) overlap = ~overlap;
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) == 0));
            if ($urandom_range(0, 299) == 0) async_reset("reset_rand_mid");
        end

        // drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d want=0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/moore_seq_detect.md
Name: moore_seq_detect

Overview:
Parametrised Moore-style serial pattern detector. It samples a 1-bit serial input `x` on each enabled clock and asserts registered output `z` for one cycle after the last PAT_W bits equal a runtime-programmable pattern. It adds overlap/non-overlap matching, input enable, synchronous clear and a saturating match counter. It sits on serial control/test streams in the FSM library.

Parameters:
- PAT_W, default 4: pattern length in bits. Legal range is 2 to 16.
- CNT_W, default 8: width of the match counter. Minimum is 1.

Ports:
- clk  input  1  system clock, rising-edge active.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  sample enable. `x` is consumed only on clocks where en=1.
- x  input  1  serial data bit.
- pattern  input  PAT_W  target pattern. pattern[PAT_W-1] is the oldest (first-received) bit and pattern[0] is the newest.
- overlap  input  1  1 = overlapping matches allowed; 0 = non-overlapping.
- clear  input  1  synchronous clear of history, `z` and counter.
- z  output  1  match flag. It is a registered state bit and is never combinational from `x`.
- match_count  output  CNT_W  number of matches since reset/clear, saturating.
- count_sat  output  1  high while match_count equals all ones.

Behaviour:
- Internal state:
  - `hist[PAT_W-1:0]`: shift history, newest bit in bit 0.
  - `fill[0..PAT_W]`: number of valid history bits.
  - `z_q` drives `z`; `cnt` drives match_count.
- Reset (asynchronous, reset=1): hist=0, fill=0, z=0, match_count=0, count_sat=0. Reset takes effect immediately, mid-pattern included, and overrides every input.
- Priority at each rising edge, reset deasserted: clear > en > idle.
- clear=1: hist<=0, fill<=0, z<=0, cnt<=0, regardless of en and x.
- en=1, clear=0:
  - nh = {hist[PAT_W-2:0], x}; nf = min(fill+1, PAT_W).
  - hit = (nh == pattern) && (nf == PAT_W).
  - hist<=nh; z<=hit.
  - If hit and cnt != all ones: cnt<=cnt+1.
  - fill update: if hit and overlap=0, fill<=0, so the next match needs PAT_W fresh bits. Otherwise fill<=nf.
- en=0, clear=0: hist, fill and cnt hold; z<=0.
- Latency: the bit completing the match is sampled at edge k. `z` is high from edge k to edge k+1, exactly one cycle per match. Back-to-back matches in overlap mode give consecutive high cycles.
- `pattern` and `overlap` are sampled on every enabled edge with no internal copy:
  - A pattern change takes effect on the next enabled edge; history is not flushed.
  - An overlap change applies to the fill update on the same edge.
- count_sat is combinational from cnt (cnt == 2^CNT_W-1). Once saturated, further matches still pulse `z` but the count holds.
- A match is impossible while fill < PAT_W: after reset/clear, the first PAT_W-1 bits can never hit, even when zeros match a zero pattern.

Test Plan (PAT_W=4, CNT_W=8, pattern=4'b1011 unless noted):
1. overlap=1, en=1, x = 1,0,1,1,0,1,1 on consecutive edges -> z high only in the cycle after bit 4 and the cycle after bit 7; match_count=2.
2. overlap=0, same stream -> z high only after bit 4 (fill reset, bits 5-7 give fill=3); match_count=1. Then x=1,0,1,1 -> one more z pulse; match_count=2.
3. Enable gaps: x=1,0 enabled; then en=0 for 3 cycles with x=0,0,0; then x=1,1 enabled -> z pulses after the 4th enabled bit, and z=0 during all en=0 cycles.
4. Zero-pattern guard: pattern=4'b0000, reset, then x=0 for 3 edges -> z stays 0. 4th x=0 -> z=1. With overlap=1 and 2 more zeros -> z stays high 3 cycles total; match_count=3.
5. Saturation, CNT_W=2, overlap=1: pattern=4'b1111, then x=1 for 8 edges -> z high 5 cycles, match_count=3, count_sat=1 from the 3rd match onward. Then clear=1 for one edge -> match_count=0, count_sat=0, z=0.
6. Reset/clear mid-operation: feed x=1,0,1; assert reset asynchronously between edges -> outputs 0 immediately. Release, then x=1 -> no match. Then x=1,0,1,1 -> match. Repeat with clear=1 and en=1 on the same edge -> clear wins, and the x sampled on that edge is discarded.
